miner_work_scheduler: RTL and testbench

//  Sequences NUM_CORES SHA-256 miner cores (fpgaminer_top-class datapaths) through one mining job.
//  - Accepts a job (midstate + 96-bit tail) on a valid/ready handshake.
//  - Splits the 32-bit nonce space into equal per-core slices and starts all cores together.
//  - Arbitrates golden-nonce reports from the cores and returns one result per job.

---
 rtl/miner_sched_pkg.sv | 19 +
 rtl/miner_found_arbiter.sv | 34 +++
 rtl/miner_work_scheduler.sv | 155 +++++++++++++++
 tb/tb_miner_work_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_sched_pkg.sv
// rtl/miner_sched_pkg.sv - shared types, widths and helpers for the miner work scheduler
package miner_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} sched_state_t;

  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int NONCE_W    = 32;
  localparam int MAX_CORES  = 16;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set_idx(input logic [MAX_CORES-1:0] bits);
    lowest_set_idx = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (bits[i]) lowest_set_idx = 4'(i);
    end
  endfunction

endpackage

// File: rtl/miner_found_arbiter.sv
// rtl/miner_found_arbiter.sv - lowest-index priority pick among cores reporting a golden nonce
module miner_found_arbiter
  import miner_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0]         found,
  input  logic [NONCE_W*NUM_CORES-1:0] nonce,
  output logic                         any_found,
  output logic [IDX_W-1:0]             win_idx,
  output logic [NONCE_W-1:0]           win_nonce
);

  logic [MAX_CORES-1:0] found_pad;
  logic [3:0]           idx_full;

  always_comb begin
    found_pad                = '0;
    found_pad[NUM_CORES-1:0] = found;
  end

  assign idx_full  = lowest_set_idx(found_pad);
  assign any_found = |found;
  assign win_idx   = idx_full[IDX_W-1:0];

  always_comb begin
    win_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (idx_full == 4'(i)) win_nonce = nonce[i*NONCE_W +: NONCE_W];
    end
  end

endmodule

// File: rtl/miner_work_scheduler.sv
// rtl/miner_work_scheduler.sv - job sequencer for NUM_CORES miner cores; MINER_HASHCOUNT_EN adds hash_count
module miner_work_scheduler
  import miner_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [MIDSTATE_W-1:0]        job_midstate,
  input  logic [DATA_W-1:0]            job_data,
  input  logic                         job_abort,
  output logic [MIDSTATE_W-1:0]        core_midstate,
  output logic [DATA_W-1:0]            core_data,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NONCE_W*NUM_CORES-1:0] core_base_nonce,
  output logic                         core_stop,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NONCE_W*NUM_CORES-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_done,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_found,
  output logic [NONCE_W-1:0]           res_nonce,
  output logic [IDX_W-1:0]             res_core
`ifdef MINER_HASHCOUNT_EN
  ,
  output logic [63:0]                  hash_count
`endif
);

  localparam int SLICE_SH = NONCE_W - $clog2(NUM_CORES);

  sched_state_t         state, state_next;
  logic                 accept, run_abort, run_found, run_done;
  logic                 any_found;
  logic [IDX_W-1:0]     win_idx;
  logic [NONCE_W-1:0]   win_nonce;

  miner_found_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_arbiter (
    .found     (core_found),
    .nonce     (core_nonce),
    .any_found (any_found),
    .win_idx   (win_idx),
    .win_nonce (win_nonce)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    run_abort  = 1'b0;
    run_found  = 1'b0;
    run_done   = 1'b0;
    case (state)
      IDLE: begin
        if (job_valid) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (job_abort) begin
          run_abort  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // core_done is a level held from the previous job until cores see start, so skip it that cycle.
        if (job_abort) begin
          run_abort  = 1'b1;
          state_next = IDLE;
        end else if (any_found) begin
          run_found  = 1'b1;
          state_next = REPORT;
        end else if ((&core_done) && !(|core_start)) begin
          run_done   = 1'b1;
          state_next = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign job_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_midstate   <= '0;
      core_data       <= '0;
      core_start      <= '0;
      core_base_nonce <= '0;
      core_stop       <= 1'b1;
      res_valid       <= 1'b0;
      res_found       <= 1'b0;
      res_nonce       <= '0;
      res_core        <= '0;
    end else begin
      core_start <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_base_nonce[i*NONCE_W +: NONCE_W] <= NONCE_W'(i) << SLICE_SH;
      end
      if (accept) begin
        core_midstate <= job_midstate;
        core_data     <= job_data;
      end
      if (state == LOAD && !job_abort) begin
        core_start <= '1;
        core_stop  <= 1'b0;
      end
      if (run_abort) core_stop <= 1'b1;
      if (run_found) begin
        res_valid <= 1'b1;
        res_found <= 1'b1;
        res_nonce <= win_nonce;
        res_core  <= win_idx;
        core_stop <= 1'b1;
      end
      if (run_done) begin
        res_valid <= 1'b1;
        res_found <= 1'b0;
        res_nonce <= '0;
        res_core  <= '0;
        core_stop <= 1'b1;
      end
      if (state == REPORT && res_ready) res_valid <= 1'b0;
    end
  end

`ifdef MINER_HASHCOUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash_count <= '0;
    end else if (state == RUN) begin
      if (hash_count > (64'hFFFF_FFFF_FFFF_FFFF - 64'(NUM_CORES))) hash_count <= '1;
      else hash_count <= hash_count + 64'(NUM_CORES);
    end
  end
`endif

endmodule

// File: tb/tb_miner_work_scheduler.sv
// tb/tb_miner_work_scheduler.sv - directed self-checking bench for miner_work_scheduler (NUM_CORES=4)
module tb_miner_work_scheduler;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid;
  logic          job_ready;
  logic [255:0]  job_midstate;
  logic [95:0]   job_data;
  logic          job_abort;
  logic [255:0]  core_midstate;
  logic [95:0]   core_data;
  logic [3:0]    core_start;
  logic [127:0]  core_base_nonce;
  logic          core_stop;
  logic [3:0]    core_found;
  logic [127:0]  core_nonce;
  logic [3:0]    core_done;
  logic          res_valid;
  logic          res_ready;
  logic          res_found;
  logic [31:0]   res_nonce;
  logic [1:0]    res_core;
`ifdef MINER_HASHCOUNT_EN
  logic [63:0]   hash_count;
`endif

  int total = 0;
  int bad   = 0;

  miner_work_scheduler #(.NUM_CORES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_midstate    (job_midstate),
    .job_data        (job_data),
    .job_abort       (job_abort),
    .core_midstate   (core_midstate),
    .core_data       (core_data),
    .core_start      (core_start),
    .core_base_nonce (core_base_nonce),
    .core_stop       (core_stop),
    .core_found      (core_found),
    .core_nonce      (core_nonce),
    .core_done       (core_done),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_found       (res_found),
    .res_nonce       (res_nonce),
    .res_core        (res_core)
`ifdef MINER_HASHCOUNT_EN
    ,
    .hash_count      (hash_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_job_ready"}, 256'(job_ready), 256'd1);
    check({tag, "_core_start"}, 256'(core_start), 256'd0);
    check({tag, "_core_stop"}, 256'(core_stop), 256'd1);
    check({tag, "_res_valid"}, 256'(res_valid), 256'd0);
    check({tag, "_res_found"}, 256'(res_found), 256'd0);
    check({tag, "_res_nonce"}, 256'(res_nonce), 256'd0);
    check({tag, "_res_core"}, 256'(res_core), 256'd0);
    check({tag, "_midstate"}, core_midstate, 256'd0);
    check({tag, "_data"}, 256'(core_data), 256'd0);
    check({tag, "_base"}, 256'(core_base_nonce), 256'd0);
  endtask

  task automatic run_job(input logic [255:0] mid, input logic [95:0] data);
    job_midstate = mid;
    job_data     = data;
    job_valid    = 1'b1;
    step();
    job_valid = 1'b0;
    check("acc_job_ready", 256'(job_ready), 256'd0);
    check("acc_midstate", core_midstate, mid);
    check("acc_data", 256'(core_data), 256'(data));
    check("acc_no_start", 256'(core_start), 256'd0);
    step();
    check("start_pulse", 256'(core_start), 256'hF);
    check("start_stop_low", 256'(core_stop), 256'd0);
    step();
    check("start_pulse_end", 256'(core_start), 256'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    job_valid    = 1'b0;
    job_midstate = '0;
    job_data     = '0;
    job_abort    = 1'b0;
    core_found   = '0;
    core_nonce   = '0;
    core_done    = '0;
    res_ready    = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst_n = 1'b1;
    step();
    check("base_nonce", 256'(core_base_nonce), 256'({32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0}));

    // Test 1: single winner on core 2
    run_job({8{32'hA5A5_0001}}, {3{32'h1234_5678}});
    core_found = 4'b0100;
    core_nonce = {32'h0, 32'h8000_1234, 32'h0, 32'h0};
    step();
    core_found = '0;
    check("t1_res_valid", 256'(res_valid), 256'd1);
    check("t1_res_found", 256'(res_found), 256'd1);
    check("t1_res_nonce", 256'(res_nonce), 256'h8000_1234);
    check("t1_res_core", 256'(res_core), 256'd2);
    check("t1_core_stop", 256'(core_stop), 256'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("t1_res_cleared", 256'(res_valid), 256'd0);
    check("t1_idle_ready", 256'(job_ready), 256'd1);

    // Test 2: simultaneous winners, lowest index wins; later report ignored
    run_job({8{32'h0000_0002}}, {3{32'h0000_0002}});
    core_found = 4'b1010;
    core_nonce = {32'hC000_0007, 32'h0, 32'h4000_0005, 32'h0};
    step();
    check("t2_res_core", 256'(res_core), 256'd1);
    check("t2_res_nonce", 256'(res_nonce), 256'h4000_0005);
    core_found = 4'b1000;
    core_nonce = {32'hC000_0099, 96'h0};
    step();
    core_found = '0;
    check("t2_keep_core", 256'(res_core), 256'd1);
    check("t2_keep_nonce", 256'(res_nonce), 256'h4000_0005);
    check("t2_keep_valid", 256'(res_valid), 256'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Test 3: nonce space exhausted
    run_job({8{32'h0000_0003}}, {3{32'h0000_0003}});
    core_done = 4'b0111;
    step();
    check("t3_partial_done", 256'(res_valid), 256'd0);
    core_done = 4'hF;
    step();
    check("t3_res_valid", 256'(res_valid), 256'd1);
    check("t3_res_found", 256'(res_found), 256'd0);
    check("t3_res_nonce", 256'(res_nonce), 256'd0);
    check("t3_core_stop", 256'(core_stop), 256'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Test 4: abort in RUN, then abort beating a same-cycle found, then a fresh job
    run_job({8{32'h0000_0004}}, {3{32'h0000_0004}});
    job_abort = 1'b1;
    step();
    job_abort = 1'b0;
    check("t4_abort_stop", 256'(core_stop), 256'd1);
    check("t4_abort_idle", 256'(job_ready), 256'd1);
    check("t4_abort_nores", 256'(res_valid), 256'd0);
    run_job({8{32'h0000_0005}}, {3{32'h0000_0005}});
    job_abort  = 1'b1;
    core_found = 4'b0001;
    core_nonce = {96'h0, 32'h0000_0777};
    core_done  = 4'hF;
    step();
    job_abort  = 1'b0;
    core_found = '0;
    core_done  = '0;
    check("t4_abort_wins", 256'(res_valid), 256'd0);
    check("t4_abort_idle2", 256'(job_ready), 256'd1);
    step();
    check("t4_no_late_res", 256'(res_valid), 256'd0);

    // Test 5: result held while res_ready is low, job offered meanwhile
    run_job({8{32'h0000_0006}}, {3{32'h0000_0006}});
    core_found = 4'b1000;
    core_nonce = {32'hDEAD_BEEF, 96'h0};
    step();
    core_found   = '0;
    job_valid    = 1'b1;
    job_midstate = {8{32'h0000_0007}};
    job_data     = {3{32'h0000_0007}};
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 256'(res_valid), 256'd1);
      check("t5_hold_nonce", 256'(res_nonce), 256'hDEAD_BEEF);
      check("t5_hold_core", 256'(res_core), 256'd3);
      check("t5_no_ready", 256'(job_ready), 256'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("t5_hs_done", 256'(res_valid), 256'd0);
    check("t5_ready_after", 256'(job_ready), 256'd1);
    check("t5_not_loaded", 256'(core_midstate), 256'({8{32'h0000_0006}}));
    step();
    job_valid = 1'b0;
    check("t5_accepted", 256'(job_ready), 256'd0);
    check("t5_loaded", core_midstate, 256'({8{32'h0000_0007}}));
    step();
    check("t5_start", 256'(core_start), 256'hF);
    step();

    // Test 6: reset during RUN
    rst_n = 1'b0;
    step();
    check_reset_values("t6");
    rst_n = 1'b1;
    step();

`ifdef MINER_HASHCOUNT_EN
    check("hc_after_reset", 256'(hash_count), 256'd0);
    run_job({8{32'h0000_0008}}, {3{32'h0000_0008}});
    repeat (99) step();
    check("hc_400", 256'(hash_count), 256'd400);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("hc_reset", 256'(hash_count), 256'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
